// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, FSM states, widths.
package alu_ctrl_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 4;

    localparam logic [OP_W-1:0] OP_MOV  = 3'b000;
    localparam logic [OP_W-1:0] OP_NOT  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b100;
    localparam logic [OP_W-1:0] OP_NAND = 3'b101;
    localparam logic [OP_W-1:0] OP_AND  = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter: on a tie the port that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       idx
);

    // One-hot grant plus its index
    always_comb begin
        gnt = 2'b00;
        idx = 1'b0;
        case (req)
            2'b01: begin
                gnt = 2'b01;
                idx = 1'b0;
            end
            2'b10: begin
                gnt = 2'b10;
                idx = 1'b1;
            end
            2'b11: begin
                if (last) begin
                    gnt = 2'b01;
                    idx = 1'b0;
                end else begin
                    gnt = 2'b10;
                    idx = 1'b1;
                end
            end
            default: begin
                gnt = 2'b00;
                idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: arbitrate, hold operands
// on the ALU for ALU_LAT cycles, capture the result and return it to the winner.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned N       = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*OP_W-1:0]   req_op,
    input  logic [2*N-1:0]      req_a,
    input  logic [2*N-1:0]      req_b,
    input  logic [1:0]          req_cin,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [N-1:0]        rsp_result,
    output logic                rsp_cout,
    output logic [OP_W-1:0]     alu_op,
    output logic [N-1:0]        alu_a,
    output logic [N-1:0]        alu_b,
    output logic                alu_cin,
    input  logic [N-1:0]        alu_result,
    input  logic                alu_cout,
    output logic                busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LAT - 1);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              g_q, g_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Operand registers double as the ALU drive: zero outside EXEC keeps the ALU quiet
    logic [OP_W-1:0]   op_q, op_d;
    logic [N-1:0]      a_q, a_d;
    logic [N-1:0]      b_q, b_d;
    logic              cin_q, cin_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [N-1:0]      res_q, res_d;
    logic              cout_q, cout_d;
    logic              busy_q, busy_d;

    logic [1:0]        arb_gnt;
    logic              arb_idx;
    logic              accept;

    rr_arb2 u_arb (
        .req  (req_valid),
        .last (last_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    // Request acceptance is only offered while idle and out of reset
    always_comb begin
        req_ready = 2'b00;
        if (state_q == S_IDLE && !rst) begin
            req_ready = arb_gnt;
        end
    end

    assign accept = |req_ready;

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        g_d         = g_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        rsp_valid_d = rsp_valid_q;
        res_d       = res_q;
        cout_d      = cout_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_EXEC;
                    g_d     = arb_idx;
                    last_d  = arb_idx;
                    cnt_d   = '0;
                    op_d    = arb_idx ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
                    a_d     = arb_idx ? req_a[2*N-1:N] : req_a[N-1:0];
                    b_d     = arb_idx ? req_b[2*N-1:N] : req_b[N-1:0];
                    cin_d   = req_cin[arb_idx];
                end
            end
            S_EXEC: begin
                if (cnt_q == LAST_CNT) begin
                    state_d     = S_RESP;
                    res_d       = alu_result;
                    cout_d      = alu_cout;
                    rsp_valid_d = g_q ? 2'b10 : 2'b01;
                    cnt_d       = '0;
                    op_d        = OP_MOV;
                    a_d         = '0;
                    b_d         = '0;
                    cin_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_valid_q[g_q] && rsp_ready[g_q]) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 2'b00;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            g_q         <= 1'b0;
            cnt_q       <= '0;
            op_q        <= OP_MOV;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            rsp_valid_q <= 2'b00;
            res_q       <= '0;
            cout_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            g_q         <= g_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            rsp_valid_q <= rsp_valid_d;
            res_q       <= res_d;
            cout_q      <= cout_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_cin    = cin_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = res_q;
    assign rsp_cout   = cout_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a transaction-level model checks one instance every
// cycle, directed literal checks pin the key scenarios, and a second instance
// exercises a three-cycle ALU latency.
module tb_alu_share_ctrl;
    import alu_ctrl_pkg::*;

    localparam int unsigned N   = 32;
    localparam int          LAT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // Instance with ALU_LAT = 1
    logic [1:0]   req_valid, req_ready, req_cin, rsp_valid, rsp_ready;
    logic [5:0]   req_op;
    logic [63:0]  req_a, req_b;
    logic [31:0]  rsp_result, alu_a, alu_b, alu_result;
    logic         rsp_cout, alu_cin, alu_cout, busy;
    logic [2:0]   alu_op;

    // Instance with ALU_LAT = 3
    logic [1:0]   t3_req_valid, t3_req_ready, t3_req_cin, t3_rsp_valid, t3_rsp_ready;
    logic [5:0]   t3_req_op;
    logic [63:0]  t3_req_a, t3_req_b;
    logic [31:0]  t3_rsp_result, t3_alu_a, t3_alu_b, t3_alu_result;
    logic         t3_rsp_cout, t3_alu_cin, t3_alu_cout, t3_busy;
    logic [2:0]   t3_alu_op;

    function automatic logic [32:0] alu_fn(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic cin);
        case (op)
            OP_MOV:  return {1'b0, a};
            OP_NOT:  return {1'b0, ~a};
            OP_ADD:  return {1'b0, a} + {1'b0, b} + 33'(cin);
            OP_NOR:  return {1'b0, ~(a | b)};
            OP_SUB:  return {1'b0, a} - {1'b0, b} - 33'(cin);
            OP_NAND: return {1'b0, ~(a & b)};
            OP_AND:  return {1'b0, a & b};
            OP_SLT:  return {1'b0, 31'd0, ($signed(a) < $signed(b))};
            default: return 33'd0;
        endcase
    endfunction

    assign {alu_cout, alu_result}       = alu_fn(alu_op, alu_a, alu_b, alu_cin);
    assign {t3_alu_cout, t3_alu_result} = alu_fn(t3_alu_op, t3_alu_a, t3_alu_b, t3_alu_cin);

    alu_share_ctrl #(.N(N), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout), .busy(busy)
    );

    alu_share_ctrl #(.N(N), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(t3_req_valid), .req_ready(t3_req_ready), .req_op(t3_req_op),
        .req_a(t3_req_a), .req_b(t3_req_b), .req_cin(t3_req_cin),
        .rsp_valid(t3_rsp_valid), .rsp_ready(t3_rsp_ready),
        .rsp_result(t3_rsp_result), .rsp_cout(t3_rsp_cout),
        .alu_op(t3_alu_op), .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_cin(t3_alu_cin),
        .alu_result(t3_alu_result), .alu_cout(t3_alu_cout), .busy(t3_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_phase: 0 = free, 1..LAT = operands on the ALU, LAT+1 = response pending
    int           m_phase = 0;
    logic         m_last  = 1'b1;
    logic         m_port  = 1'b0;
    logic [2:0]   m_op;
    logic [31:0]  m_a, m_b, m_res;
    logic         m_cin, m_cout;

    function automatic logic [1:0] pick(logic [1:0] v, logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    always @(negedge clk) begin : model_check
        logic [1:0]  e_rdy, e_rsp, sel;
        logic        e_busy;
        logic [2:0]  e_op;
        logic [31:0] e_a, e_b;
        logic        e_cin;
        if (rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_alu_a", 64'(alu_a), 64'(0));
            m_phase = 0;
            m_last  = 1'b1;
        end else begin
            e_rdy = 2'b00; e_rsp = 2'b00; e_busy = 1'b0;
            e_op = 3'd0; e_a = 32'd0; e_b = 32'd0; e_cin = 1'b0;
            if (m_phase == 0) begin
                e_rdy = pick(req_valid, m_last);
            end else if (m_phase <= LAT) begin
                e_busy = 1'b1;
                e_op = m_op; e_a = m_a; e_b = m_b; e_cin = m_cin;
            end else begin
                e_busy = 1'b1;
                e_rsp  = m_port ? 2'b10 : 2'b01;
            end
            chk("m_req_ready", 64'(req_ready), 64'(e_rdy));
            chk("m_rsp_valid", 64'(rsp_valid), 64'(e_rsp));
            chk("m_busy", 64'(busy), 64'(e_busy));
            chk("m_alu", {29'd0, alu_op, alu_cin, alu_a}, {29'd0, e_op, e_cin, e_a});
            chk("m_alu_b", 64'(alu_b), 64'(e_b));
            if (e_rsp != 2'b00) begin
                chk("m_rsp_result", 64'(rsp_result), 64'(m_res));
                chk("m_rsp_cout", 64'(rsp_cout), 64'(m_cout));
            end
            // advance the model with the inputs the DUT sees at the next edge
            if (m_phase == 0) begin
                if (req_valid != 2'b00) begin
                    sel    = pick(req_valid, m_last);
                    m_port = sel[1];
                    m_op   = m_port ? req_op[5:3]   : req_op[2:0];
                    m_a    = m_port ? req_a[63:32]  : req_a[31:0];
                    m_b    = m_port ? req_b[63:32]  : req_b[31:0];
                    m_cin  = req_cin[m_port];
                    {m_cout, m_res} = alu_fn(m_op, m_a, m_b, m_cin);
                    m_last  = m_port;
                    m_phase = 1;
                end
            end else if (m_phase <= LAT) begin
                m_phase++;
            end else if (rsp_ready[m_port]) begin
                m_phase = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(output logic idx, output int at);
        idx = 1'b0;
        at  = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                idx = req_ready[1];
                at  = cyc;
                return;
            end
            @(posedge clk);
            #1;
        end
        total++;
        bad++;
        $display("FAIL accept_timeout at cycle %0d: got no grant want a grant", cyc);
    endtask

    task automatic set_req(input logic p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin);
        if (p) begin
            req_op[5:3] = op; req_a[63:32] = a; req_b[63:32] = b; req_cin[1] = cin;
        end else begin
            req_op[2:0] = op; req_a[31:0] = a; req_b[31:0] = b; req_cin[0] = cin;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic g;
        int   t0, t1, tp;
        logic [2:0] ops [8];
        ops = '{OP_MOV, OP_NOT, OP_ADD, OP_NOR, OP_SUB, OP_NAND, OP_AND, OP_SLT};

        rst = 1'b1;
        req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0; req_cin = 2'b00; rsp_ready = 2'b11;
        t3_req_valid = 2'b00; t3_req_op = '0; t3_req_a = '0; t3_req_b = '0; t3_req_cin = 2'b00;
        t3_rsp_ready = 2'b11;
        step; step;
        @(negedge clk);
        chk("reset_rsp_result", 64'(rsp_result), 64'(0));
        chk("reset_rsp_cout", 64'(rsp_cout), 64'(0));
        chk("reset_busy3", 64'(t3_busy), 64'(0));
        step;
        rst = 1'b0;

        // single op on port 0: ADD 5+7
        set_req(1'b0, OP_ADD, 32'd5, 32'd7, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        chk("single_ready", 64'(req_ready), 64'(2'b01));
        step;
        req_valid = 2'b00;
        @(negedge clk);
        chk("single_t1_rsp_valid", 64'(rsp_valid), 64'(0));
        step;
        @(negedge clk);
        chk("single_t2_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        chk("single_result", 64'(rsp_result), 64'(12));
        chk("single_cout", 64'(rsp_cout), 64'(0));
        step;
        @(negedge clk);
        chk("single_done_busy", 64'(busy), 64'(0));

        // reset in the middle of EXEC drops the op
        step;
        set_req(1'b1, OP_MOV, 32'hDEAD, 32'h0, 1'b0);
        req_valid = 2'b10;
        @(negedge clk);
        chk("rstx_ready", 64'(req_ready), 64'(2'b10));
        step;
        req_valid = 2'b00;
        chk("rstx_exec_alu_a", 64'(alu_a), 64'(32'hDEAD));
        rst = 1'b1;
        @(negedge clk);
        chk("rstx_busy", 64'(busy), 64'(0));
        chk("rstx_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rstx_alu_a", 64'(alu_a), 64'(0));
        step;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rstx_no_rsp", 64'(rsp_valid), 64'(0));
            step;
        end

        // tie after reset: port 0 first, then port 1 (SUB 9-3)
        set_req(1'b0, OP_ADD, 32'd1, 32'd2, 1'b0);
        set_req(1'b1, OP_SUB, 32'd9, 32'd3, 1'b0);
        req_valid = 2'b11;
        wait_accept(g, t0);
        chk("tie_first", 64'(g), 64'(0));
        step;
        wait_accept(g, t1);
        chk("tie_second", 64'(g), 64'(1));
        chk("tie_gap", 64'(t1 - t0), 64'(3));
        step;
        req_valid = 2'b00;
        @(negedge clk);
        chk("tie_t1_rsp_valid", 64'(rsp_valid), 64'(0));
        step;
        @(negedge clk);
        chk("tie_rsp_valid", 64'(rsp_valid), 64'(2'b10));
        chk("tie_result", 64'(rsp_result), 64'(6));
        step;

        // backpressure on the response channel
        rsp_ready = 2'b00;
        set_req(1'b0, OP_AND, 32'hFF00, 32'h0FF0, 1'b0);
        req_valid = 2'b01;
        wait_accept(g, t0);
        chk("bp_port", 64'(g), 64'(0));
        step;
        req_valid = 2'b11;
        step;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'(2'b01));
            chk("bp_result", 64'(rsp_result), 64'(32'h0F00));
            chk("bp_req_ready", 64'(req_ready), 64'(0));
            step;
        end
        rsp_ready = 2'b11;
        req_valid = 2'b00;
        @(negedge clk);
        chk("bp_release_valid", 64'(rsp_valid), 64'(2'b01));
        step;
        @(negedge clk);
        chk("bp_done_busy", 64'(busy), 64'(0));
        chk("bp_done_rsp_valid", 64'(rsp_valid), 64'(0));

        // fairness: both always valid for six ops; data changed after each accept
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        set_req(1'b0, OP_ADD, 32'd100, 32'd23, 1'b1);
        set_req(1'b1, OP_SLT, 32'hFFFF_FFF0, 32'd4, 1'b0);
        req_valid = 2'b11;
        tp = 0;
        for (int i = 0; i < 6; i++) begin
            wait_accept(g, t0);
            chk("fair_grant", 64'(g), 64'(i % 2));
            if (i > 0) chk("fair_gap", 64'(t0 - tp), 64'(3));
            tp = t0;
            step;
            set_req(g, ops[(i * 3 + 1) % 8], 32'(i * 1234567 + 89), 32'(i * 7654321 + 5), 1'(i));
        end
        req_valid = 2'b00;
        repeat (4) step;

        // three-cycle ALU latency with carry out
        t3_req_op[5:3]   = OP_ADD;
        t3_req_a[63:32]  = 32'hFFFF_FFFF;
        t3_req_b[63:32]  = 32'd1;
        t3_req_cin[1]    = 1'b0;
        t3_req_valid     = 2'b10;
        @(negedge clk);
        chk("lat3_ready", 64'(t3_req_ready), 64'(2'b10));
        step;
        t3_req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lat3_alu_a", 64'(t3_alu_a), 64'(32'hFFFF_FFFF));
            chk("lat3_busy", 64'(t3_busy), 64'(1));
            chk("lat3_no_rsp", 64'(t3_rsp_valid), 64'(0));
            step;
        end
        @(negedge clk);
        chk("lat3_rsp_valid", 64'(t3_rsp_valid), 64'(2'b10));
        chk("lat3_result", 64'(t3_rsp_result), 64'(0));
        chk("lat3_cout", 64'(t3_rsp_cout), 64'(1));
        chk("lat3_alu_idle", 64'(t3_alu_a), 64'(0));
        step;
        @(negedge clk);
        chk("lat3_done_busy", 64'(t3_busy), 64'(0));
        step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
